// File: rtl/diaosi_types_pkg.sv
// Shared enums for the memory arbiter: RAM handshake states and arbiter FSM.
// Imported by the arbiter RTL and its bench.
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle for the memory arbiter.
// slave is the arbiter's view; master is the caches-plus-RAM view.
interface mem_arbiter_if;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates dcache and icache traffic onto a single-ported RAM.
// Data wins, a streak counter forces instruction progress, a timer drops stuck accesses.
module mem_arbiter
    import diaosi_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_TOP = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TCNT_TOP   = TW'(TIMEOUT - 1);

    arb_state_t    state, next_state;
    logic [SW-1:0] dstreak, next_dstreak;
    logic [TW-1:0] tcnt, next_tcnt;
    logic          err_q, err_set;
    logic          dreq;
    ramstate_t     rs;

    assign dreq    = bus.dREN | bus.dWEN;
    assign rs      = ramstate_t'(bus.ramstate);
    assign bus.err = err_q;

    always_comb begin
        next_state   = state;
        next_dstreak = dstreak;
        next_tcnt    = '0;
        err_set      = 1'b0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        unique case (state)
            ARB: begin
                if (bus.iREN && (dstreak == STREAK_TOP || !dreq)) begin
                    next_state   = ISERV;
                    next_dstreak = '0;
                end else if (dreq) begin
                    next_state = DSERV;
                    if (!bus.iREN)
                        next_dstreak = '0;
                    else if (dstreak != STREAK_TOP)
                        next_dstreak = dstreak + SW'(1);
                end
            end
            DSERV: begin
                if (!dreq) begin
                    next_state = ARB;
                end else begin
                    bus.ramaddr = bus.daddr;
                    if (bus.dWEN) begin
                        bus.ramWEN   = 1'b1;
                        bus.ramstore = bus.dstore;
                        err_set      = bus.dREN;
                    end else begin
                        bus.ramREN = 1'b1;
                    end
                    if (rs == ACCESS) begin
                        bus.dwait  = 1'b0;
                        bus.dload  = bus.ramload;
                        next_state = ARB;
                    end else begin
                        if (rs == ERROR)
                            err_set = 1'b1;
                        if (tcnt == TCNT_TOP) begin
                            err_set    = 1'b1;
                            next_state = ARB;
                        end
                    end
                end
            end
            ISERV: begin
                if (!bus.iREN) begin
                    next_state = ARB;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (rs == ACCESS) begin
                        bus.iwait  = 1'b0;
                        bus.iload  = bus.ramload;
                        next_state = ARB;
                    end else begin
                        if (rs == ERROR)
                            err_set = 1'b1;
                        if (tcnt == TCNT_TOP) begin
                            err_set    = 1'b1;
                            next_state = ARB;
                        end
                    end
                end
            end
            default: next_state = ARB;
        endcase

        // Count only SERV cycles that stay in SERV; saturate rather than wrap.
        if (next_state != ARB && state != ARB)
            next_tcnt = (tcnt == TCNT_TOP) ? tcnt : tcnt + TW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ARB;
            dstreak <= '0;
            tcnt    <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= next_state;
            dstreak <= next_dstreak;
            tcnt    <= next_tcnt;
            err_q   <= err_q | err_set;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic,
// every cycle compared against a grant-level reference model.
module tb_mem_arbiter;
    import diaosi_types_pkg::*;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // model: who holds the grant (0 none, 1 data, 2 instr), streak, SERV age
    int m_gnt, m_streak, m_age;
    bit m_err;

    logic        s_iwait, s_dwait, s_ren, s_wen, s_err;
    logic [31:0] s_dload, s_iload, s_store;
    int          cur_run, last_run;
    byte         comp[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = 0; m_streak = 0; m_age = 0; m_err = 0;
        cur_run = 0;
    endtask

    task automatic drive(input bit ir, input bit dr, input bit dw,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input logic [1:0] rst8,
                         input logic [31:0] rl);
        bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
        bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
        bus.ramstate = rst8; bus.ramload = rl;
    endtask

    task automatic step();
        int n_gnt, n_streak, n_age;
        bit set_err, dreq, greq;
        logic e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_st, e_il, e_dl;
        @(negedge CLK);
        n_gnt = m_gnt; n_streak = m_streak; set_err = 0;
        e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0;
        e_addr = 0; e_st = 0; e_il = 0; e_dl = 0;
        dreq = bus.dREN | bus.dWEN;
        greq = (m_gnt == 1) ? dreq : bus.iREN;
        if (m_gnt == 0) begin
            if (bus.iREN && (m_streak == STARVE_MAX || !dreq)) begin
                n_gnt = 2; n_streak = 0;
            end else if (dreq) begin
                n_gnt = 1;
                n_streak = bus.iREN ? ((m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX) : 0;
            end
        end else if (!greq) begin
            n_gnt = 0;
        end else begin
            if (m_gnt == 1) begin
                e_addr = bus.daddr;
                if (bus.dWEN) begin
                    e_wen = 1; e_st = bus.dstore;
                    if (bus.dREN) set_err = 1;
                end else e_ren = 1;
            end else begin
                e_addr = bus.iaddr; e_ren = 1;
            end
            if (bus.ramstate == ACCESS) begin
                if (m_gnt == 1) begin e_dw = 0; e_dl = bus.ramload; end
                else begin e_iw = 0; e_il = bus.ramload; end
                n_gnt = 0;
            end else begin
                if (bus.ramstate == ERROR) set_err = 1;
                if (m_age + 1 >= TIMEOUT) begin set_err = 1; n_gnt = 0; end
            end
        end
        n_age = (n_gnt != 0 && m_gnt != 0) ? m_age + 1 : 0;

        chk("iwait", bus.iwait, e_iw);
        chk("dwait", bus.dwait, e_dw);
        chk("iload", bus.iload, e_il);
        chk("dload", bus.dload, e_dl);
        chk("ramREN", bus.ramREN, e_ren);
        chk("ramWEN", bus.ramWEN, e_wen);
        chk("ramaddr", bus.ramaddr, e_addr);
        chk("ramstore", bus.ramstore, e_st);
        chk("err", bus.err, m_err);

        s_iwait = bus.iwait; s_dwait = bus.dwait; s_ren = bus.ramREN;
        s_wen = bus.ramWEN; s_err = bus.err; s_dload = bus.dload;
        s_iload = bus.iload; s_store = bus.ramstore;
        if (bus.ramREN | bus.ramWEN) cur_run++;
        else begin
            if (cur_run > 0) last_run = cur_run;
            cur_run = 0;
        end
        if (!bus.dwait) comp.push_back("D");
        if (!bus.iwait) comp.push_back("I");

        @(posedge CLK);
        m_gnt = n_gnt; m_streak = n_streak; m_age = n_age;
        m_err = m_err | set_err;
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        repeat (n) step();
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    initial begin
        byte exp_seq[6];
        int  r;
        logic [1:0] rs_r;
        exp_seq = '{"D", "D", "D", "D", "I", "D"};
        last_run = 0;
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, FREE, 32'hFFFF_FFFF);
        #12;
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_dwait", bus.dwait, 1);
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_err", bus.err, 0);
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
        idle(2);

        // data read with two BUSY cycles
        drive(0, 1, 0, 0, 32'h100, 0, FREE, 0);
        step();
        chk("rd_arb_ren", s_ren, 0);
        bus.ramstate = BUSY;
        step(); step();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEAD_BEEF;
        step();
        chk("rd_dwait", s_dwait, 0);
        chk("rd_dload", s_dload, 32'hDEAD_BEEF);
        chk("rd_iwait", s_iwait, 1);
        idle(1);
        chk("rd_dwait_after", s_dwait, 1);

        // simultaneous instr + data write
        drive(1, 0, 1, 32'h40, 32'h200, 32'h1234, FREE, 32'h55);
        step();
        step();
        chk("sim_wen", s_wen, 1);
        chk("sim_store", s_store, 32'h1234);
        bus.ramstate = ACCESS;
        step();
        chk("sim_dwait", s_dwait, 0);
        bus.dWEN = 0;
        step();
        step();
        chk("sim_iwait", s_iwait, 0);
        chk("sim_iload", s_iload, 32'h55);
        idle(1);

        // starvation: data stream with a pending fetch
        comp.delete();
        drive(1, 1, 0, 32'h44, 32'h300, 0, ACCESS, 32'h77);
        repeat (12) step();
        chk("starve_len", comp.size(), 6);
        for (int i = 0; i < 6 && i < comp.size(); i++)
            chk($sformatf("starve_g%0d", i), comp[i], exp_seq[i]);
        idle(1);

        // abort before ACCESS
        drive(0, 1, 0, 0, 32'h400, 0, BUSY, 0);
        step();
        bus.dREN = 0;
        step();
        chk("abort_ren", s_ren, 0);
        chk("abort_err", s_err, 0);
        idle(2);

        // ERROR then BUSY until timeout, then regrant
        drive(0, 1, 0, 0, 32'h500, 0, FREE, 0);
        step();
        bus.ramstate = ERROR;
        step();
        chk("err_sticky", bus.err, 1);
        bus.ramstate = BUSY;
        repeat (TIMEOUT - 1) step();
        step();
        chk("tmo_drop", s_ren, 0);
        chk("tmo_run", last_run, TIMEOUT);
        step();
        chk("tmo_regrant", s_ren, 1);
        idle(2);

        // reset in the middle of an instruction access
        drive(1, 0, 0, 32'h80, 0, 0, BUSY, 0);
        step(); step();
        #2 RST = 1'b1;
        #1;
        chk("mrst_iwait", bus.iwait, 1);
        chk("mrst_ren", bus.ramREN, 0);
        chk("mrst_err", bus.err, 0);
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
        step();
        chk("mrst_arb", s_ren, 0);
        bus.ramstate = ACCESS;
        step();
        idle(1);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            if (k % 600 == 599) pulse_reset();
            r = $urandom_range(0, 99);
            rs_r = (r < 40) ? ACCESS : (r < 85) ? BUSY : (r < 97) ? FREE : ERROR;
            r = $urandom_range(0, 99);
            drive($urandom_range(0, 99) < 60,
                  r < 45, (r >= 45 && r < 75) || r == 99,
                  $urandom, $urandom, $urandom, rs_r, $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
